// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: state encoding, special opcodes,
// memory timeout limit and instruction-field positions within mach_code.
package core_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [8:0] HALT_CODE   = 9'h1FF;
    localparam logic [3:0] MEM_TIMEOUT = 4'd15;

    localparam int BRANCH_BIT = 8;
    localparam int LDR_BIT    = 7;
    localparam int WENR_BIT   = 6;
    localparam int JPTR_HI    = 3;
    localparam int JPTR_LO    = 2;

    // Loads set LDR; stores are encoded by WENR being clear.
    function automatic logic is_mem_op(input logic [8:0] code);
        return code[LDR_BIT] | ~code[WENR_BIT];
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM cycles spent waiting for the data memory and flags the cycle in
// which the wait would reach the timeout limit.
module mem_wait_timer
    import core_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    input  logic rdy,
    output logic expired
);

    logic [3:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (tick && !rdy && (count_reg != MEM_TIMEOUT)) begin
            count_reg <= count_reg + 4'd1;
        end
    end

    // Expires in the wait cycle that takes the count to the limit; rdy wins.
    assign expired = tick && !rdy && (count_reg == (MEM_TIMEOUT - 4'd1));

endmodule

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with a
// memory-wait timeout. Every output is a register updated on state transitions.
module core_seq
    import core_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [8:0]  mach_code,
    input  logic        Zero,
    input  logic        MemRdy,
    output logic        IrLoad,
    output logic        PcInc,
    output logic        PcJump,
    output logic        RegWen,
    output logic        DmemRen,
    output logic        DmemWen,
    output logic        Ack,
    output logic        Fault,
    output logic [15:0] InstrCnt,
    output logic [2:0]  State
);

    state_t      state_reg;
    logic        armed_reg;
    logic        ir_load_reg;
    logic        pc_inc_reg;
    logic        pc_jump_reg;
    logic        reg_wen_reg;
    logic        dmem_ren_reg;
    logic        dmem_wen_reg;
    logic        ack_reg;
    logic        fault_reg;
    logic [15:0] instr_cnt_reg;

    logic timer_clear;
    logic timer_tick;
    logic timer_expired;
    logic wb_jump;
    logic mem_op;

    assign timer_clear = (state_reg == EXEC);
    assign timer_tick  = (state_reg == MEM);
    assign mem_op      = is_mem_op(mach_code);
    // Zero is sampled on the edge that enters WB so PcJump/PcInc are registered.
    assign wb_jump     = mach_code[BRANCH_BIT] & Zero;

    mem_wait_timer u_mem_wait_timer (
        .clk     (Clk),
        .rst     (Reset),
        .clear   (timer_clear),
        .tick    (timer_tick),
        .rdy     (MemRdy),
        .expired (timer_expired)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            armed_reg     <= 1'b0;
            ir_load_reg   <= 1'b0;
            pc_inc_reg    <= 1'b0;
            pc_jump_reg   <= 1'b0;
            reg_wen_reg   <= 1'b0;
            dmem_ren_reg  <= 1'b0;
            dmem_wen_reg  <= 1'b0;
            ack_reg       <= 1'b0;
            fault_reg     <= 1'b0;
            instr_cnt_reg <= '0;
        end else begin
            // The first edge after reset only arms the FSM; it cannot leave IDLE.
            armed_reg   <= 1'b1;
            ir_load_reg <= 1'b0;
            pc_inc_reg  <= 1'b0;
            pc_jump_reg <= 1'b0;
            reg_wen_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (Start && armed_reg) begin
                        state_reg     <= FETCH;
                        ir_load_reg   <= 1'b1;
                        instr_cnt_reg <= '0;
                        fault_reg     <= 1'b0;
                    end
                end
                FETCH: begin
                    state_reg <= DECODE;
                end
                DECODE: begin
                    if (mach_code == HALT_CODE) begin
                        state_reg <= HALT;
                        ack_reg   <= 1'b1;
                    end else begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (mem_op) begin
                        state_reg    <= MEM;
                        dmem_ren_reg <= mach_code[LDR_BIT];
                        dmem_wen_reg <= ~mach_code[WENR_BIT];
                    end else begin
                        state_reg   <= WB;
                        reg_wen_reg <= mach_code[WENR_BIT];
                        pc_jump_reg <= wb_jump;
                        pc_inc_reg  <= ~wb_jump;
                    end
                end
                MEM: begin
                    if (MemRdy) begin
                        state_reg    <= WB;
                        dmem_ren_reg <= 1'b0;
                        dmem_wen_reg <= 1'b0;
                        reg_wen_reg  <= mach_code[WENR_BIT];
                        pc_jump_reg  <= wb_jump;
                        pc_inc_reg   <= ~wb_jump;
                    end else if (timer_expired) begin
                        state_reg    <= HALT;
                        dmem_ren_reg <= 1'b0;
                        dmem_wen_reg <= 1'b0;
                        fault_reg    <= 1'b1;
                        ack_reg      <= 1'b1;
                    end
                end
                WB: begin
                    state_reg   <= FETCH;
                    ir_load_reg <= 1'b1;
                    if (instr_cnt_reg != 16'hFFFF) begin
                        instr_cnt_reg <= instr_cnt_reg + 16'd1;
                    end
                end
                HALT: begin
                    if (!Start) begin
                        state_reg <= IDLE;
                        ack_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    dmem_ren_reg <= 1'b0;
                    dmem_wen_reg <= 1'b0;
                    ack_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign IrLoad   = ir_load_reg;
    assign PcInc    = pc_inc_reg;
    assign PcJump   = pc_jump_reg;
    assign RegWen   = reg_wen_reg;
    assign DmemRen  = dmem_ren_reg;
    assign DmemWen  = dmem_wen_reg;
    assign Ack      = ack_reg;
    assign Fault    = fault_reg;
    assign InstrCnt = instr_cnt_reg;
    assign State    = state_reg;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: runs hand-picked instructions and compares
// cycle counts, strobes and status against hand-computed values.
module tb_core_seq;
    import core_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [8:0]  mach_code;
    logic        Zero;
    logic        MemRdy;
    logic        IrLoad, PcInc, PcJump, RegWen, DmemRen, DmemWen, Ack, Fault;
    logic [15:0] InstrCnt;
    logic [2:0]  State;

    int compared   = 0;
    int mismatched = 0;

    int   n_cyc, n_ren, n_wen, n_irl;
    logic any_wen, wb_jump, wb_inc, wb_wen;
    int   end_state;

    core_seq dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .mach_code (mach_code),
        .Zero      (Zero),
        .MemRdy    (MemRdy),
        .IrLoad    (IrLoad),
        .PcInc     (PcInc),
        .PcJump    (PcJump),
        .RegWen    (RegWen),
        .DmemRen   (DmemRen),
        .DmemWen   (DmemWen),
        .Ack       (Ack),
        .Fault     (Fault),
        .InstrCnt  (InstrCnt),
        .State     (State)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Called while the DUT sits in FETCH; runs until WB or HALT is reached.
    // rdy_at = index of the MEM cycle carrying MemRdy=1, or -1 for never.
    task automatic exec_instr(input logic [8:0] code, input logic zero_in, input int rdy_at);
        int mem_idx;
        bit done;
        mach_code = code;
        Zero      = zero_in;
        MemRdy    = 1'b0;
        n_cyc = 1; n_ren = 0; n_wen = 0; n_irl = 0;
        any_wen = 1'b0; wb_jump = 1'b0; wb_inc = 1'b0; wb_wen = 1'b0;
        mem_idx = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            n_cyc++;
            if (IrLoad) n_irl++;
            any_wen = any_wen | RegWen;
            if (State == 3'(MEM)) begin
                n_ren += int'(DmemRen);
                n_wen += int'(DmemWen);
                MemRdy = (mem_idx == rdy_at);
                mem_idx++;
            end else if (State == 3'(WB)) begin
                wb_jump = PcJump;
                wb_inc  = PcInc;
                wb_wen  = RegWen;
                done = 1'b1;
            end else if (State == 3'(HALT)) begin
                done = 1'b1;
            end
        end
        MemRdy    = 1'b0;
        end_state = int'(State);
        check({"bound_", $sformatf("%03h", code)}, int'(done), 1);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b1; mach_code = 9'h041; Zero = 1'b0; MemRdy = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_state", int'(State), int'(IDLE));
        check("rst_strobes", int'({IrLoad, PcInc, PcJump, RegWen, DmemRen, DmemWen}), 0);
        check("rst_ack_fault", int'({Ack, Fault}), 0);
        check("rst_cnt", int'(InstrCnt), 0);
        Reset = 1'b0;

        // Start already high: the first edge after reset must stay in IDLE.
        step();
        check("first_edge_idle", int'(State), int'(IDLE));
        step();
        check("start_fetch", int'(State), int'(FETCH));
        check("fetch_irload", int'(IrLoad), 1);

        // ALU op
        exec_instr(9'h041, 1'b0, -1);
        check("alu_cycles", n_cyc, 4);
        check("alu_irload_once", n_irl, 0);
        check("alu_wb_regwen", int'(wb_wen), 1);
        check("alu_wb_pcinc", int'(wb_inc), 1);
        check("alu_wb_pcjump", int'(wb_jump), 0);
        step();
        check("alu_cnt", int'(InstrCnt), 1);

        // Load with MemRdy on the 4th MEM cycle
        exec_instr(9'h0C0, 1'b0, 3);
        check("ld_cycles", n_cyc, 8);
        check("ld_ren_cycles", n_ren, 4);
        check("ld_wen_cycles", n_wen, 0);
        check("ld_wb_regwen", int'(wb_wen), 1);
        step();
        check("ld_cnt", int'(InstrCnt), 2);

        // Branch (store-encoded) taken and not taken
        exec_instr(9'h108, 1'b1, 0);
        check("br1_cycles", n_cyc, 5);
        check("br1_pcjump", int'(wb_jump), 1);
        check("br1_pcinc", int'(wb_inc), 0);
        check("br1_regwen", int'(any_wen), 0);
        step();
        exec_instr(9'h108, 1'b0, 0);
        check("br0_pcjump", int'(wb_jump), 0);
        check("br0_pcinc", int'(wb_inc), 1);
        step();
        check("br_cnt", int'(InstrCnt), 4);

        // MemRdy in the would-be timeout cycle wins
        exec_instr(9'h000, 1'b0, 14);
        check("prio_state", end_state, int'(WB));
        check("prio_cycles", n_cyc, 19);
        check("prio_fault", int'(Fault), 0);
        check("prio_wen_cycles", n_wen, 15);
        step();
        check("prio_cnt", int'(InstrCnt), 5);

        // Store timeout
        exec_instr(9'h000, 1'b0, -1);
        check("to_state", end_state, int'(HALT));
        check("to_wen_cycles", n_wen, 15);
        check("to_ren_cycles", n_ren, 0);
        check("to_fault_ack", int'({Fault, Ack}), 3);
        check("to_regwen", int'(any_wen), 0);
        check("to_strobes", int'({PcInc, PcJump, DmemRen, DmemWen}), 0);
        check("to_cnt", int'(InstrCnt), 5);
        step();
        check("to_hold", int'(State), int'(HALT));
        Start = 1'b0;
        step();
        check("to_idle", int'(State), int'(IDLE));
        check("to_idle_fault", int'({Ack, Fault}), 1);
        Start = 1'b1;
        step();
        check("restart_fetch", int'(State), int'(FETCH));
        check("restart_clr", int'({Fault, InstrCnt}), 0);

        // HALT code with Start held three cycles
        exec_instr(9'h1FF, 1'b0, -1);
        check("halt_state", end_state, int'(HALT));
        check("halt_cycles", n_cyc, 3);
        check("halt_ack", int'(Ack), 1);
        repeat (3) step();
        check("halt_hold", int'({State, Ack}), (int'(HALT) << 1) | 1);
        Start = 1'b0;
        step();
        check("halt_idle", int'(State), int'(IDLE));
        check("halt_ack_low", int'(Ack), 0);

        // Reset asserted in the middle of a MEM wait
        Start = 1'b1;
        step();
        exec_instr(9'h041, 1'b0, -1);
        step();
        check("pre_rst_cnt", int'(InstrCnt), 1);
        mach_code = 9'h000;
        repeat (3) step();
        check("pre_rst_mem", int'({State, DmemWen}), (int'(MEM) << 1) | 1);
        #2 Reset = 1'b1;
        #1;
        check("mid_rst_state", int'(State), int'(IDLE));
        check("mid_rst_wen", int'(DmemWen), 0);
        check("mid_rst_cnt", int'(InstrCnt), 0);
        Start = 1'b0;
        step();
        Reset = 1'b0;
        repeat (2) step();
        check("post_rst_idle", int'(State), int'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
